// File: rtl/execute_stage_v2_if.sv
// Pipeline signals between the decode/register-read stage, the execute stage and the E->M register.
interface execute_stage_v2_if #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
);
  logic               valid_e;
  logic               RegWriteE;
  logic               MemWriteE;
  logic               ResultSrcE;
  logic               ALUSrcE;
  logic               BranchE;
  logic               JumpE;
  logic [3:0]         ALUControlE;
  logic [2:0]         BranchOpE;
  logic [XLEN-1:0]    RD1_E;
  logic [XLEN-1:0]    RD2_E;
  logic [XLEN-1:0]    Imm_Ext_E;
  logic [XLEN-1:0]    PCE;
  logic [XLEN-1:0]    PCPlus4E;
  logic [REGADDR-1:0] RD_E;
  logic [1:0]         ForwardAE;
  logic [1:0]         ForwardBE;
  logic [XLEN-1:0]    ResultW;
  logic               stall_m;

  logic               PCSrcE;
  logic [XLEN-1:0]    PCTargetE;
  logic               busy_e;
  logic               valid_m;
  logic               RegWriteM;
  logic               MemWriteM;
  logic               ResultSrcM;
  logic [REGADDR-1:0] RD_M;
  logic [XLEN-1:0]    PCPlus4M;
  logic [XLEN-1:0]    WriteDataM;
  logic [XLEN-1:0]    ALUResultM;

  modport master (
    output valid_e, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE,
           ALUControlE, BranchOpE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardAE, ForwardBE, ResultW, stall_m,
    input  PCSrcE, PCTargetE, busy_e, valid_m, RegWriteM, MemWriteM, ResultSrcM,
           RD_M, PCPlus4M, WriteDataM, ALUResultM
  );

  modport slave (
    input  valid_e, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE,
           ALUControlE, BranchOpE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardAE, ForwardBE, ResultW, stall_m,
    output PCSrcE, PCTargetE, busy_e, valid_m, RegWriteM, MemWriteM, ResultSrcM,
           RD_M, PCPlus4M, WriteDataM, ALUResultM
  );
endinterface

// File: rtl/execute_stage_v2.sv
// RV32I execute stage: forwarding, ALU, branch resolution and the E->M register.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier (ALUControlE = 10).
//
// state | meaning
// IDLE  | no multiply in flight; a MUL request latches operands and stalls E
// RUN   | one shift-add step per cycle, XLEN steps, E held busy
// DONE  | product on the ALU result, waits for ~stall_m to hand it to M
module execute_stage_v2 #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input logic               clk,
  input logic               rst,
  execute_stage_v2_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] alu_out;
  logic            busy;
  logic            cond;

  always_comb begin
    case (bus.ForwardAE)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = bus.ALUResultM;
      default: src_a = bus.RD1_E;
    endcase
    case (bus.ForwardBE)
      2'b01:   fwd_b = bus.ResultW;
      2'b10:   fwd_b = bus.ALUResultM;
      default: fwd_b = bus.RD2_E;
    endcase
    src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (bus.ALUControlE)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_SLL:  alu_res = src_a << src_b[SHW-1:0];
      OP_SRL:  alu_res = src_a >> src_b[SHW-1:0];
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> src_b[SHW-1:0]);
      default: alu_res = '0;
    endcase
  end

  // Branches compare against the forwarded rs2, never the immediate.
  always_comb begin
    cond = 1'b0;
    case (bus.BranchOpE)
      3'b000:  cond = (src_a == fwd_b);
      3'b001:  cond = (src_a != fwd_b);
      3'b100:  cond = ($signed(src_a) < $signed(fwd_b));
      3'b101:  cond = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  cond = (src_a < fwd_b);
      3'b111:  cond = (src_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

`ifdef EXEC_MUL_EN
  localparam logic [3:0]     OP_MUL   = 4'd10;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_t;

  mul_state_t      state;
  mul_state_t      state_nx;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;
  logic            mul_req;

  assign mul_req = ~rst & bus.valid_e & (bus.ALUControlE == OP_MUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      S_IDLE: begin
        if (mul_req) begin
          busy     = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nx = S_DONE;
      end
      S_DONE: begin
        if (!bus.stall_m) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operands are latched so forwarded sources may change while RUN proceeds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_IDLE) begin
      if (mul_req) begin
        mcand  <= src_a;
        mplier <= src_b;
        acc    <= '0;
        cnt    <= '0;
      end
    end else if (state == S_RUN) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHW'(1);
    end
  end

  assign alu_out = (state == S_DONE) ? acc : alu_res;
`else
  assign busy    = 1'b0;
  assign alu_out = alu_res;
`endif

  assign bus.busy_e    = busy;
  assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
  assign bus.PCSrcE    = bus.valid_e & ~busy & (bus.JumpE | (bus.BranchE & cond));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_m    <= 1'b0;
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.ResultSrcM <= 1'b0;
      bus.RD_M       <= '0;
      bus.PCPlus4M   <= '0;
      bus.WriteDataM <= '0;
      bus.ALUResultM <= '0;
    end else if (!bus.stall_m) begin
      if (busy) begin
        bus.valid_m    <= 1'b0;
        bus.RegWriteM  <= 1'b0;
        bus.MemWriteM  <= 1'b0;
        bus.ResultSrcM <= 1'b0;
        bus.RD_M       <= '0;
        bus.PCPlus4M   <= '0;
        bus.WriteDataM <= '0;
        bus.ALUResultM <= '0;
      end else begin
        bus.valid_m    <= bus.valid_e;
        bus.RegWriteM  <= bus.RegWriteE & bus.valid_e;
        bus.MemWriteM  <= bus.MemWriteE & bus.valid_e;
        bus.ResultSrcM <= bus.ResultSrcE;
        bus.RD_M       <= bus.RD_E;
        bus.PCPlus4M   <= bus.PCPlus4E;
        bus.WriteDataM <= fwd_b;
        bus.ALUResultM <= alu_out;
      end
    end
  end
endmodule

// File: tb/tb_execute_stage_v2.sv
// Self-checking bench for execute_stage_v2 (XLEN=32); follows EXEC_MUL_EN when defined.
module tb_execute_stage_v2;
  localparam int XLEN    = 32;
  localparam int REGADDR = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  execute_stage_v2_if #(.XLEN(XLEN), .REGADDR(REGADDR)) bus();
  execute_stage_v2 #(.XLEN(XLEN), .REGADDR(REGADDR)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: E->M register contents plus multiply progress.
  logic [31:0] m_alu = '0, m_wd = '0, m_pc4 = '0;
  logic [4:0]  m_rd = '0;
  logic        m_valid = 1'b0, m_rw = 1'b0, m_mw = 1'b0, m_rs = 1'b0, m_dc = 1'b0;
  int          run_left = 0;
  logic        mul_done = 1'b0;
  logic [31:0] prod = '0;

  function automatic logic [31:0] src_a_ref();
    case (bus.ForwardAE)
      2'b01:   return bus.ResultW;
      2'b10:   return m_alu;
      default: return bus.RD1_E;
    endcase
  endfunction

  function automatic logic [31:0] fwd_b_ref();
    case (bus.ForwardBE)
      2'b01:   return bus.ResultW;
      2'b10:   return m_alu;
      default: return bus.RD2_E;
    endcase
  endfunction

  function automatic logic [31:0] src_b_ref();
    return bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b_ref();
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic cond_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return !($signed(a) < $signed(b));
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic busy_exp();
`ifdef EXEC_MUL_EN
    return !rst && (run_left > 0 || (!mul_done && bus.valid_e && bus.ALUControlE == 4'd10));
`else
    return 1'b0;
`endif
  endfunction

  task automatic cap(input logic [31:0] alu);
    m_valid <= bus.valid_e;
    m_rw    <= bus.RegWriteE & bus.valid_e;
    m_mw    <= bus.MemWriteE & bus.valid_e;
    m_rs    <= bus.ResultSrcE;
    m_rd    <= bus.RD_E;
    m_pc4   <= bus.PCPlus4E;
    m_wd    <= fwd_b_ref();
    m_alu   <= alu;
    m_dc    <= 1'b0;
  endtask

  task automatic bubble();
    m_valid <= 1'b0;
    m_rw    <= 1'b0;
    m_mw    <= 1'b0;
    m_dc    <= 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_alu <= '0; m_wd <= '0; m_pc4 <= '0; m_rd <= '0;
      m_valid <= 1'b0; m_rw <= 1'b0; m_mw <= 1'b0; m_rs <= 1'b0; m_dc <= 1'b0;
      run_left <= 0; mul_done <= 1'b0; prod <= '0;
    end else begin
`ifdef EXEC_MUL_EN
      if (mul_done) begin
        if (!bus.stall_m) begin
          cap(prod);
          mul_done <= 1'b0;
        end
      end else if (run_left > 0) begin
        run_left <= run_left - 1;
        if (run_left == 1) mul_done <= 1'b1;
        if (!bus.stall_m) bubble();
      end else if (bus.valid_e && bus.ALUControlE == 4'd10) begin
        run_left <= 32;
        prod     <= src_a_ref() * src_b_ref();
        if (!bus.stall_m) bubble();
      end else if (!bus.stall_m) begin
        cap(alu_ref(bus.ALUControlE, src_a_ref(), src_b_ref()));
      end
`else
      if (!bus.stall_m) cap(alu_ref(bus.ALUControlE, src_a_ref(), src_b_ref()));
`endif
    end
  end

  always @(negedge clk) begin
    chk("busy_e", 32'(bus.busy_e), 32'(busy_exp()));
    chk("PCTargetE", bus.PCTargetE, bus.PCE + bus.Imm_Ext_E);
    chk("PCSrcE", 32'(bus.PCSrcE), 32'(bus.valid_e & !busy_exp() &
        (bus.JumpE | (bus.BranchE & cond_ref(bus.BranchOpE, src_a_ref(), fwd_b_ref())))));
    chk("valid_m", 32'(bus.valid_m), 32'(m_valid));
    chk("RegWriteM", 32'(bus.RegWriteM), 32'(m_rw));
    chk("MemWriteM", 32'(bus.MemWriteM), 32'(m_mw));
    if (!m_dc) begin
      chk("ResultSrcM", 32'(bus.ResultSrcM), 32'(m_rs));
      chk("RD_M", 32'(bus.RD_M), 32'(m_rd));
      chk("PCPlus4M", bus.PCPlus4M, m_pc4);
      chk("WriteDataM", bus.WriteDataM, m_wd);
      chk("ALUResultM", bus.ALUResultM, m_alu);
    end
  end

  logic [2:0]  br_f [8] = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b101, 3'b111, 3'b010, 3'b011};
  logic [31:0] br_a [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5};
  logic [31:0] br_b [8] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd1, 32'd1, 32'd5, 32'd5};
  logic        br_x [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic [3:0]  alu_op [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11};
  logic [31:0] alu_x  [10] = '{32'h8000_000C, 32'h0, 32'h8000_0014, 32'h8000_0014, 32'h1,
                               32'h0, 32'h0000_0100, 32'h0800_0001, 32'hF800_0001, 32'h0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.valid_e = 0; bus.RegWriteE = 0; bus.MemWriteE = 0; bus.ResultSrcE = 0;
    bus.ALUSrcE = 0; bus.BranchE = 0; bus.JumpE = 0; bus.ALUControlE = 0; bus.BranchOpE = 0;
    bus.RD1_E = 0; bus.RD2_E = 0; bus.Imm_Ext_E = 0; bus.PCE = 0; bus.PCPlus4E = 0;
    bus.RD_E = 0; bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0; bus.stall_m = 0;
  endtask

`ifdef EXEC_MUL_EN
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic stall_run,
                         input logic stall_done, input logic [31:0] exp);
    int n;
    n = 0;
    idle_in();
    bus.valid_e = 1; bus.RegWriteE = 1; bus.ALUControlE = 4'd10;
    bus.RD1_E = a; bus.RD2_E = b; bus.RD_E = 5'd7;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.busy_e) break;
      n++;
      bus.stall_m = stall_run && (n >= 5 && n < 9);
      if (n == 12) bus.RD1_E = 32'h1234_5678;
      @(posedge clk);
    end
    chk("mul_busy_cycles", n, 33);
    bus.stall_m = stall_done;
    if (stall_done) begin
      repeat (2) begin
        tick();
        chk("mul_done_stall_busy", 32'(bus.busy_e), 0);
        chk("mul_done_stall_valid_m", 32'(bus.valid_m), 0);
      end
      bus.stall_m = 0;
    end
    tick();
    chk("mul_result", bus.ALUResultM, exp);
    chk("mul_valid_m", 32'(bus.valid_m), 1);
    chk("mul_rd_m", 32'(bus.RD_M), 7);
    idle_in();
  endtask
`endif

  initial begin
    idle_in();
    rst = 1;
    tick(); tick();
    chk("rst_valid_m", 32'(bus.valid_m), 0);
    chk("rst_alu", bus.ALUResultM, 0);
    chk("rst_busy", 32'(bus.busy_e), 0);
    rst = 0;

    bus.valid_e = 1; bus.RegWriteE = 1; bus.RD1_E = 5; bus.RD2_E = 7; bus.RD_E = 3;
    bus.PCPlus4E = 32'h104;
    tick();
    chk("add_alu", bus.ALUResultM, 12);
    chk("add_rd", 32'(bus.RD_M), 3);
    chk("add_regwrite", 32'(bus.RegWriteM), 1);
    chk("add_valid", 32'(bus.valid_m), 1);
    chk("add_pc4", bus.PCPlus4M, 32'h104);

    bus.RD1_E = 60; bus.RD2_E = 40;
    tick();
    chk("fwd_setup", bus.ALUResultM, 100);
    bus.ForwardAE = 2'b10; bus.RD1_E = 1; bus.Imm_Ext_E = 32'hFFFF_FFFC; bus.ALUSrcE = 1;
    tick();
    chk("fwd_a_mem", bus.ALUResultM, 96);
    bus.ForwardAE = 0; bus.ALUSrcE = 0; bus.ForwardBE = 2'b01; bus.ResultW = 32'h55;
    bus.RD2_E = 32'h99; bus.MemWriteE = 1; bus.RegWriteE = 0;
    tick();
    chk("fwd_b_wd", bus.WriteDataM, 32'h55);
    chk("fwd_b_alu", bus.ALUResultM, 32'h56);
    chk("fwd_b_memwrite", 32'(bus.MemWriteM), 1);

    idle_in();
    bus.valid_e = 1; bus.BranchE = 1; bus.ALUSrcE = 1; bus.Imm_Ext_E = 8;
    for (int i = 0; i < 8; i++) begin
      bus.BranchOpE = br_f[i]; bus.RD1_E = br_a[i]; bus.RD2_E = br_b[i];
      #1;
      chk($sformatf("branch_f%0b", br_f[i]), 32'(bus.PCSrcE), 32'(br_x[i]));
    end
    bus.BranchE = 0; bus.JumpE = 1;
    #1 chk("jump", 32'(bus.PCSrcE), 1);
    bus.valid_e = 0;
    #1 chk("jump_invalid", 32'(bus.PCSrcE), 0);
    bus.PCE = 32'hFFFF_FFFC; bus.Imm_Ext_E = 8;
    #1 chk("target_wrap", bus.PCTargetE, 32'h4);

    idle_in();
    bus.valid_e = 1; bus.RegWriteE = 1; bus.RD1_E = 32'h8000_0010; bus.RD2_E = 4;
    for (int i = 0; i < 10; i++) begin
      bus.ALUControlE = alu_op[i];
      tick();
      chk($sformatf("alu_op%0d", alu_op[i]), bus.ALUResultM, alu_x[i]);
    end
    bus.ALUControlE = 4'd7; bus.RD2_E = 32'h21;
    tick();
    chk("sll_shamt_mask", bus.ALUResultM, 32'h20);

    bus.valid_e = 0; bus.MemWriteE = 1; bus.RegWriteE = 1;
    tick();
    chk("bubble_memwrite", 32'(bus.MemWriteM), 0);
    chk("bubble_regwrite", 32'(bus.RegWriteM), 0);
    chk("bubble_valid", 32'(bus.valid_m), 0);

    idle_in();
    bus.valid_e = 1; bus.RD1_E = 3; bus.RD2_E = 4; bus.RD_E = 9;
    tick();
    chk("stall_setup", bus.ALUResultM, 7);
    bus.stall_m = 1; bus.RD1_E = 100; bus.RD_E = 1;
    repeat (3) begin
      tick();
      chk("stall_alu", bus.ALUResultM, 7);
      chk("stall_rd", 32'(bus.RD_M), 9);
    end
    bus.stall_m = 0;
    tick();
    chk("stall_release", bus.ALUResultM, 104);

`ifdef EXEC_MUL_EN
    run_mul(32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0, 32'hFFFF_FFFF);
    run_mul(32'd3, 32'd5, 1'b1, 1'b1, 32'd15);
`else
    idle_in();
    bus.valid_e = 1; bus.RegWriteE = 1; bus.ALUControlE = 4'd10;
    bus.RD1_E = 32'h0000_FFFF; bus.RD2_E = 32'h0001_0001;
    #1 chk("nomul_busy", 32'(bus.busy_e), 0);
    tick();
    chk("nomul_result", bus.ALUResultM, 0);
    chk("nomul_valid", 32'(bus.valid_m), 1);
`endif

    idle_in();
    bus.valid_e = 1; bus.RegWriteE = 1; bus.RD1_E = 32'h11; bus.RD2_E = 32'h22; bus.RD_E = 5;
    tick();
`ifdef EXEC_MUL_EN
    bus.stall_m = 1; bus.ALUControlE = 4'd10; bus.RD1_E = 3; bus.RD2_E = 3;
    repeat (11) tick();
    chk("rst_pre_busy", 32'(bus.busy_e), 1);
`endif
    chk("rst_pre_alu", bus.ALUResultM, 32'h33);
    rst = 1;
    #1;
    chk("rst_mid_alu", bus.ALUResultM, 0);
    chk("rst_mid_valid", 32'(bus.valid_m), 0);
    chk("rst_mid_regwrite", 32'(bus.RegWriteM), 0);
    chk("rst_mid_busy", 32'(bus.busy_e), 0);
    tick();
    rst = 0;
    idle_in();
    bus.valid_e = 1; bus.RegWriteE = 1; bus.RD1_E = 2; bus.RD2_E = 3; bus.RD_E = 4;
    tick();
    chk("post_rst_add", bus.ALUResultM, 5);
    chk("post_rst_valid", 32'(bus.valid_m), 1);

    idle_in();
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
